// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-bit count / normalise pipeline.
package lzc_pkg;

  localparam int CHUNK_W = 8;

  // Count field must hold 0..width inclusive, hence one bit more than log2.
  function automatic int cnt_w_f(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_chunk8.sv
// Combinational leading-zero count of one 8-bit chunk; 8 means the chunk is all zero.
module lzc_chunk8
  import lzc_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_data,
  output logic [3:0]         o_cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = 4'(CHUNK_W);
    for (int i = 0; i < CHUNK_W; i++) begin
      o_cnt = i_data[i] ? 4'(CHUNK_W - 1 - i) : o_cnt;
    end
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero/one counter with left normalisation and valid/ready flow control.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int CNT_W = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_all,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NCH = WIDTH / CHUNK_W;

  logic [WIDTH-1:0]       w_inv;
  logic [NCH-1:0][3:0]    w_chunk_cnt;
  logic                   w_s1_load;
  logic                   w_s2_load;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_stop;
  logic                   w_all;
  logic [WIDTH-1:0]       w_norm;

  logic                   r_s1_valid;
  logic [NCH-1:0][3:0]    r_s1_cnt;
  logic [NCH-1:0]         r_s1_all;
  logic [WIDTH-1:0]       r_s1_data;
  logic [TAG_W-1:0]       r_s1_tag;

  logic                   r_s2_valid;
  logic [CNT_W-1:0]       r_s2_cnt;
  logic                   r_s2_all;
  logic [WIDTH-1:0]       r_s2_norm;
  logic [TAG_W-1:0]       r_s2_tag;

  // Leading ones are counted as leading zeros of the inverted word.
  assign w_inv = in_data ^ {WIDTH{in_mode}};

  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    lzc_chunk8 u_chunk (
      .i_data (w_inv[k*CHUNK_W +: CHUNK_W]),
      .o_cnt  (w_chunk_cnt[k])
    );
  end

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // Stage 1: per-chunk counts and all-flags, plus the original word and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_s1_all   <= '0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cnt  <= w_chunk_cnt;
        r_s1_data <= in_data;
        r_s1_tag  <= in_tag;
        for (int k = 0; k < NCH; k++) begin
          r_s1_all[k] <= (w_chunk_cnt[k] == 4'd8);
        end
      end
    end
  end

  // Sum chunk counts from the top down, stopping after the first partial chunk.
  always_comb begin
    w_cnt  = '0;
    w_stop = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_cnt  = w_stop ? w_cnt : w_cnt + CNT_W'(r_s1_cnt[k]);
      w_stop = w_stop | ~r_s1_all[k];
    end
    w_all  = ~w_stop;
    w_norm = w_all ? '0 : (r_s1_data << w_cnt);
  end

  // Stage 2: combined result; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_cnt   <= '0;
      r_s2_all   <= 1'b0;
      r_s2_norm  <= '0;
      r_s2_tag   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_cnt  <= w_cnt;
        r_s2_all  <= w_all;
        r_s2_norm <= w_norm;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_cnt   = r_s2_cnt;
  assign out_all   = r_s2_all;
  assign out_norm  = r_s2_norm;
  assign out_tag   = r_s2_tag;

endmodule
